// File: rtl/decoder_stage_controller_v2_pkg.sv
// Shared stage encodings and result status codes for the union-find decoder stage controllers.
package decoder_stage_controller_v2_pkg;

  localparam int unsigned STAGE_WIDTH = 3;

  typedef enum logic [STAGE_WIDTH-1:0] {
    STAGE_IDLE        = 3'd0,
    STAGE_LOADING     = 3'd1,
    STAGE_SPREAD      = 3'd2,
    STAGE_SYNC        = 3'd3,
    STAGE_GROW        = 3'd4,
    STAGE_CALC        = 3'd5,
    STAGE_RESULT_HOLD = 3'd6
  } stage_e;

  localparam logic [1:0] RESULT_STATUS_OK         = 2'd0;
  localparam logic [1:0] RESULT_STATUS_DEADLOCK   = 2'd1;
  localparam logic [1:0] RESULT_STATUS_ITER_LIMIT = 2'd2;

  // Stages in which a round is actively being decoded (cycle counter runs).
  function automatic logic is_decode_stage(input stage_e s);
    return (s == STAGE_LOADING) || (s == STAGE_SPREAD) || (s == STAGE_SYNC) ||
           (s == STAGE_GROW) || (s == STAGE_CALC);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/decoder_stage_controller_v2_watchdog.sv
// stage_watchdog: consecutive-cycle counter that flags when the count, including the
// current cycle, exceeds THRESHOLD.
module stage_watchdog #(
  parameter int unsigned THRESHOLD = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CW = $clog2(THRESHOLD + 2);
  localparam logic [CW-1:0] LIMIT = CW'(THRESHOLD + 1);

  logic [CW-1:0] count_q, count_d, count_inc;

  always_comb begin
    count_inc = (count_q == LIMIT) ? count_q : count_q + CW'(1);
    count_d   = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en) begin
      count_d = count_inc;
    end
    expired = count_en && !clear && (count_inc == LIMIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/decoder_stage_controller_v2.sv
// Union-find decoder stage sequencer: LOADING -> SPREAD/SYNC/GROW loops -> CALC -> RESULT_HOLD.
// Define STAGE_CTRL_PERF_COUNTERS_EN to build the cumulative per-stage perf counters.
module decoder_stage_controller_v2
  import decoder_stage_controller_v2_pkg::*;
#(
  parameter int unsigned ITERATION_COUNTER_WIDTH = 8,
  parameter int unsigned DELAY_WIDTH             = 4,
  parameter int unsigned MAX_ITERATIONS          = 255,
  parameter int unsigned DEADLOCK_THRESHOLD      = 1024,
  parameter int unsigned CYCLE_COUNTER_WIDTH     = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               new_round_start,
  output logic                               start_pending,
  input  logic                               load_done,
  input  logic [DELAY_WIDTH-1:0]             cfg_spread_delay,
  input  logic [DELAY_WIDTH-1:0]             cfg_sync_delay,
  input  logic [DELAY_WIDTH-1:0]             cfg_grow_delay,
  input  logic                               has_message_flying,
  input  logic                               has_odd_clusters,
  output logic                               calc_go,
  input  logic                               calc_done,
  output logic [STAGE_WIDTH-1:0]             stage,
  output logic                               result_valid,
  input  logic                               result_ready,
  output logic [1:0]                         result_status,
  output logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
  output logic [CYCLE_COUNTER_WIDTH-1:0]     cycle_counter,
  output logic                               deadlock,
  output logic [31:0]                        perf_spread_cycles,
  output logic [31:0]                        perf_sync_cycles,
  output logic [31:0]                        perf_grow_cycles
);

  localparam logic [ITERATION_COUNTER_WIDTH-1:0] ITER_CAP = ITERATION_COUNTER_WIDTH'(MAX_ITERATIONS);

  stage_e                             stage_q, stage_d;
  logic                               pend_q, pend_d;
  logic                               calc_go_q, calc_go_d;
  logic                               dead_q, dead_d;
  logic [1:0]                         status_q, status_d;
  logic [ITERATION_COUNTER_WIDTH-1:0] iter_q, iter_d, iter_inc;
  logic [CYCLE_COUNTER_WIDTH-1:0]     cyc_q, cyc_d;
  logic [DELAY_WIDTH-1:0]             dly_q, dly_d, dly_lim;
  logic [DELAY_WIDTH-1:0]             sd_q, sd_d, yd_q, yd_d, gd_q, gd_d;
  logic                               start, dly_met, ss_active, wd_expired;

  assign ss_active = (stage_q == STAGE_SPREAD) || (stage_q == STAGE_SYNC);

  stage_watchdog #(
    .THRESHOLD(DEADLOCK_THRESHOLD)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .count_en(ss_active),
    .clear   (!ss_active),
    .expired (wd_expired)
  );

  always_comb begin
    stage_d  = stage_q;
    pend_d   = pend_q;
    status_d = status_q;
    iter_d   = iter_q;
    dead_d   = dead_q;
    cyc_d    = cyc_q;
    sd_d     = sd_q;
    yd_d     = yd_q;
    gd_d     = gd_q;
    start    = 1'b0;
    iter_inc = iter_q + ITERATION_COUNTER_WIDTH'(1);

    case (stage_q)
      STAGE_SPREAD: dly_lim = sd_q;
      STAGE_SYNC:   dly_lim = yd_q;
      STAGE_GROW:   dly_lim = gd_q;
      default:      dly_lim = '0;
    endcase
    dly_met = (dly_q >= dly_lim);

    if (is_decode_stage(stage_q) && (cyc_q != '1)) begin
      cyc_d = cyc_q + CYCLE_COUNTER_WIDTH'(1);
    end
    if (new_round_start && (stage_q != STAGE_IDLE) &&
        !((stage_q == STAGE_RESULT_HOLD) && result_ready)) begin
      pend_d = 1'b1;
    end

    case (stage_q)
      STAGE_IDLE:    start = new_round_start || pend_q;
      STAGE_LOADING: if (load_done) stage_d = STAGE_SPREAD;
      STAGE_SPREAD:  if (dly_met && !has_message_flying) stage_d = STAGE_SYNC;
      STAGE_SYNC: begin
        if (dly_met && !has_message_flying) begin
          iter_d = iter_inc;
          if (has_odd_clusters && (iter_inc == ITER_CAP)) begin
            stage_d  = STAGE_RESULT_HOLD;
            status_d = RESULT_STATUS_ITER_LIMIT;
          end else if (has_odd_clusters) begin
            stage_d = STAGE_GROW;
          end else begin
            stage_d = STAGE_CALC;
          end
        end
      end
      STAGE_GROW:    if (dly_met) stage_d = STAGE_SPREAD;
      STAGE_CALC: begin
        if (calc_done) begin
          stage_d  = STAGE_RESULT_HOLD;
          status_d = RESULT_STATUS_OK;
        end
      end
      STAGE_RESULT_HOLD: begin
        if (result_ready) begin
          if (new_round_start || pend_q) start = 1'b1;
          else stage_d = STAGE_IDLE;
        end
      end
      default: stage_d = STAGE_IDLE;
    endcase

    // Watchdog abort overrides whatever SPREAD/SYNC decided this cycle, including the SYNC count.
    if (wd_expired) begin
      stage_d  = STAGE_RESULT_HOLD;
      iter_d   = iter_q;
      status_d = RESULT_STATUS_DEADLOCK;
      dead_d   = 1'b1;
    end

    if (start) begin
      stage_d = STAGE_LOADING;
      pend_d  = 1'b0;
      iter_d  = '0;
      dead_d  = 1'b0;
      cyc_d   = CYCLE_COUNTER_WIDTH'(1);
      sd_d    = cfg_spread_delay;
      yd_d    = cfg_sync_delay;
      gd_d    = cfg_grow_delay;
    end

    dly_d     = (stage_d != stage_q) ? '0 : (dly_met ? dly_q : dly_q + DELAY_WIDTH'(1));
    calc_go_d = (stage_d == STAGE_CALC) && (stage_q != STAGE_CALC);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q   <= STAGE_IDLE;
      pend_q    <= 1'b0;
      calc_go_q <= 1'b0;
      dead_q    <= 1'b0;
      status_q  <= RESULT_STATUS_OK;
      iter_q    <= '0;
      cyc_q     <= '0;
      dly_q     <= '0;
      sd_q      <= '0;
      yd_q      <= '0;
      gd_q      <= '0;
    end else begin
      stage_q   <= stage_d;
      pend_q    <= pend_d;
      calc_go_q <= calc_go_d;
      dead_q    <= dead_d;
      status_q  <= status_d;
      iter_q    <= iter_d;
      cyc_q     <= cyc_d;
      dly_q     <= dly_d;
      sd_q      <= sd_d;
      yd_q      <= yd_d;
      gd_q      <= gd_d;
    end
  end

  assign stage             = stage_q;
  assign start_pending     = pend_q;
  assign calc_go           = calc_go_q;
  assign result_valid      = (stage_q == STAGE_RESULT_HOLD);
  assign result_status     = status_q;
  assign iteration_counter = iter_q;
  assign cycle_counter     = cyc_q;
  assign deadlock          = dead_q;

`ifdef STAGE_CTRL_PERF_COUNTERS_EN
  logic [31:0] perf_spread_q, perf_spread_d, perf_sync_q, perf_sync_d, perf_grow_q, perf_grow_d;

  always_comb begin
    perf_spread_d = sat_inc32(perf_spread_q, stage_q == STAGE_SPREAD);
    perf_sync_d   = sat_inc32(perf_sync_q, stage_q == STAGE_SYNC);
    perf_grow_d   = sat_inc32(perf_grow_q, stage_q == STAGE_GROW);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_spread_q <= '0;
      perf_sync_q   <= '0;
      perf_grow_q   <= '0;
    end else begin
      perf_spread_q <= perf_spread_d;
      perf_sync_q   <= perf_sync_d;
      perf_grow_q   <= perf_grow_d;
    end
  end

  assign perf_spread_cycles = perf_spread_q;
  assign perf_sync_cycles   = perf_sync_q;
  assign perf_grow_cycles   = perf_grow_q;
`else
  assign perf_spread_cycles = '0;
  assign perf_sync_cycles   = '0;
  assign perf_grow_cycles   = '0;
`endif

endmodule

// File: tb/tb_decoder_stage_controller_v2.sv
// Randomized and directed bench for decoder_stage_controller_v2 against a cycle-stepped reference model.
module tb_decoder_stage_controller_v2;
  import decoder_stage_controller_v2_pkg::*;

  localparam int unsigned MAXI = 4;
  localparam int unsigned TH   = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_round_start = 1'b0, load_done = 1'b0, has_message_flying = 1'b0;
  logic        has_odd_clusters = 1'b0, calc_done = 1'b0, result_ready = 1'b0;
  logic [3:0]  cfg_spread_delay = '0, cfg_sync_delay = '0, cfg_grow_delay = '0;
  logic        start_pending, calc_go, result_valid, deadlock;
  logic [2:0]  stage;
  logic [1:0]  result_status;
  logic [7:0]  iteration_counter;
  logic [31:0] cycle_counter, perf_spread_cycles, perf_sync_cycles, perf_grow_cycles;

  decoder_stage_controller_v2 #(
    .ITERATION_COUNTER_WIDTH(8),
    .DELAY_WIDTH(4),
    .MAX_ITERATIONS(MAXI),
    .DEADLOCK_THRESHOLD(TH),
    .CYCLE_COUNTER_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset), .new_round_start(new_round_start), .start_pending(start_pending),
    .load_done(load_done), .cfg_spread_delay(cfg_spread_delay), .cfg_sync_delay(cfg_sync_delay),
    .cfg_grow_delay(cfg_grow_delay), .has_message_flying(has_message_flying),
    .has_odd_clusters(has_odd_clusters), .calc_go(calc_go), .calc_done(calc_done), .stage(stage),
    .result_valid(result_valid), .result_ready(result_ready), .result_status(result_status),
    .iteration_counter(iteration_counter), .cycle_counter(cycle_counter), .deadlock(deadlock),
    .perf_spread_cycles(perf_spread_cycles), .perf_sync_cycles(perf_sync_cycles),
    .perf_grow_cycles(perf_grow_cycles)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0, n_pass = 0;

  // Reference model: current stage, cycles spent in it, and per-round bookkeeping.
  stage_e      m_stage;
  int          m_age, m_run, m_sd, m_yd, m_gd;
  bit          m_pend, m_dead;
  int unsigned m_iter, m_cyc, m_psp, m_psy, m_pgr;
  logic [1:0]  m_status;

  int unsigned obs_go, obs_grow, obs_spread, obs_pend, hold_iter;
  logic [1:0]  hold_status;
  bit          hold_seen, hold_dead, nrs_fired;
  int          mode;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_stage = STAGE_IDLE; m_age = 0; m_run = 0; m_pend = 0; m_dead = 0;
    m_iter = 0; m_cyc = 0; m_status = 2'd0; m_sd = 0; m_yd = 0; m_gd = 0;
    m_psp = 0; m_psy = 0; m_pgr = 0;
  endtask

  task automatic model_step(input bit nrs, ld, fly, odd, cd, rdy);
    stage_e ns;
    bit     start;
    ns = m_stage;
    start = 0;
    if (nrs && m_stage != STAGE_IDLE && !(m_stage == STAGE_RESULT_HOLD && rdy)) m_pend = 1;
    if (m_stage == STAGE_SPREAD) m_psp++;
    if (m_stage == STAGE_SYNC) m_psy++;
    if (m_stage == STAGE_GROW) m_pgr++;
    m_run = (m_stage inside {STAGE_SPREAD, STAGE_SYNC}) ? m_run + 1 : 0;
    if (m_stage inside {STAGE_LOADING, STAGE_SPREAD, STAGE_SYNC, STAGE_GROW, STAGE_CALC}) m_cyc++;
    if (m_run > int'(TH)) begin
      ns = STAGE_RESULT_HOLD; m_dead = 1; m_status = 2'd1;
    end else begin
      case (m_stage)
        STAGE_IDLE:    start = nrs || m_pend;
        STAGE_LOADING: if (ld) ns = STAGE_SPREAD;
        STAGE_SPREAD:  if (m_age >= m_sd && !fly) ns = STAGE_SYNC;
        STAGE_SYNC: begin
          if (m_age >= m_yd && !fly) begin
            m_iter++;
            if (odd && m_iter == MAXI) begin ns = STAGE_RESULT_HOLD; m_status = 2'd2; end
            else ns = odd ? STAGE_GROW : STAGE_CALC;
          end
        end
        STAGE_GROW:    if (m_age >= m_gd) ns = STAGE_SPREAD;
        STAGE_CALC:    if (cd) begin ns = STAGE_RESULT_HOLD; m_status = 2'd0; end
        default:       if (rdy) begin if (nrs || m_pend) start = 1; else ns = STAGE_IDLE; end
      endcase
    end
    if (start) begin
      ns = STAGE_LOADING; m_pend = 0; m_iter = 0; m_dead = 0; m_cyc = 1;
      m_sd = int'(cfg_spread_delay); m_yd = int'(cfg_sync_delay); m_gd = int'(cfg_grow_delay);
    end
    m_age = (ns == m_stage) ? m_age + 1 : 0;
    m_stage = ns;
  endtask

  task automatic check_outputs();
    check("stage", stage, m_stage);
    check("start_pending", start_pending, m_pend);
    check("calc_go", calc_go, (m_stage == STAGE_CALC) && (m_age == 0));
    check("result_valid", result_valid, m_stage == STAGE_RESULT_HOLD);
    check("result_status", result_status, m_status);
    check("iteration_counter", iteration_counter, m_iter);
    check("cycle_counter", cycle_counter, m_cyc);
    check("deadlock", deadlock, m_dead);
`ifdef STAGE_CTRL_PERF_COUNTERS_EN
    check("perf_spread", perf_spread_cycles, m_psp);
    check("perf_sync", perf_sync_cycles, m_psy);
    check("perf_grow", perf_grow_cycles, m_pgr);
`else
    check("perf_spread", perf_spread_cycles, 0);
    check("perf_sync", perf_sync_cycles, 0);
    check("perf_grow", perf_grow_cycles, 0);
`endif
    if (calc_go) obs_go++;
    if (stage == STAGE_GROW) obs_grow++;
    if (stage == STAGE_SPREAD) obs_spread++;
    if (start_pending) obs_pend++;
    if (result_valid && !hold_seen) begin
      hold_seen = 1; hold_status = result_status; hold_iter = iteration_counter; hold_dead = deadlock;
    end
  endtask

  task automatic step(input bit nrs, ld, fly, odd, cd, rdy);
    new_round_start = nrs; load_done = ld; has_message_flying = fly;
    has_odd_clusters = odd; calc_done = cd; result_ready = rdy;
    model_step(nrs, ld, fly, odd, cd, rdy);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic pick(output bit nrs, ld, fly, odd, cd, rdy);
    nrs = 0; fly = 0; odd = 0;
    ld  = (m_stage == STAGE_LOADING) && (m_age >= 1);
    cd  = (m_stage == STAGE_CALC) && (m_age >= 5);
    rdy = (m_stage == STAGE_RESULT_HOLD) && (m_age >= 3);
    case (mode)
      1: odd = (m_iter < 3);
      2: odd = 1;
      3: fly = 1;
      4: begin
        odd = (m_iter < 2);
        if (m_stage == STAGE_GROW && !nrs_fired) begin nrs = 1; nrs_fired = 1; end
      end
      5: begin
        nrs = $urandom_range(0, 99) < ((m_stage == STAGE_IDLE) ? 30 : 4);
        ld  = $urandom_range(0, 99) < 30;
        fly = $urandom_range(0, 99) < 25;
        odd = $urandom_range(0, 99) < 50;
        cd  = $urandom_range(0, 99) < 30;
        rdy = $urandom_range(0, 99) < 40;
      end
      default: ;
    endcase
  endtask

  task automatic run_until_idle();
    bit nrs, ld, fly, odd, cd, rdy;
    for (int i = 0; i < 400; i++) begin
      if (m_stage == STAGE_IDLE) break;
      pick(nrs, ld, fly, odd, cd, rdy);
      step(nrs, ld, fly, odd, cd, rdy);
    end
    check("round_end_stage", stage, STAGE_IDLE);
  endtask

  task automatic run_round(input int md, input int sd, input int yd, input int gd);
    mode = md;
    cfg_spread_delay = 4'(sd); cfg_sync_delay = 4'(yd); cfg_grow_delay = 4'(gd);
    obs_go = 0; obs_grow = 0; obs_spread = 0; obs_pend = 0; hold_seen = 0; nrs_fired = 0;
    step(1, 0, 0, 0, 0, 0);
    run_until_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got %0d, expected %0d", 0, 1);
    $fatal(1);
  end

  initial begin
    bit nrs, ld, fly, odd, cd, rdy;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b0;
    step(0, 0, 0, 0, 0, 0);

    run_round(0, 2, 2, 3);
    check("A_calc_go_pulses", obs_go, 1);
    check("A_status", hold_status, RESULT_STATUS_OK);
    check("A_iterations", hold_iter, 1);

    run_round(1, 2, 2, 3);
    check("B_iterations", hold_iter, 4);
    check("B_grow_cycles", obs_grow, 3 * (3 + 1));
    check("B_status", hold_status, RESULT_STATUS_OK);

    run_round(2, 2, 2, 3);
    check("C_status", hold_status, RESULT_STATUS_ITER_LIMIT);
    check("C_iterations", hold_iter, MAXI);
    check("C_calc_go_pulses", obs_go, 0);

    run_round(3, 2, 2, 3);
    check("D_deadlock", hold_dead, 1);
    check("D_status", hold_status, RESULT_STATUS_DEADLOCK);
    check("D_spread_cycles", obs_spread, TH + 1);

    run_round(0, 0, 0, 0);
    check("zero_delay_deadlock_cleared", hold_dead, 0);

    run_round(4, 2, 2, 3);
    check("E_pending_seen", obs_pend != 0, 1);
    check("E_calc_go_pulses", obs_go, 2);

    mode = 5;
    for (int i = 0; i < 4000; i++) begin
      cfg_spread_delay = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      cfg_sync_delay   = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      cfg_grow_delay   = 4'($urandom_range(0, 15));
      pick(nrs, ld, fly, odd, cd, rdy);
      step(nrs, ld, fly, odd, cd, rdy);
    end
    mode = 0;
    cfg_spread_delay = 4'd2; cfg_sync_delay = 4'd2; cfg_grow_delay = 4'd3;
    run_until_idle();

    // Asynchronous reset in the middle of SYNC.
    mode = 1;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 50; i++) begin
      if (m_stage == STAGE_SYNC) break;
      pick(nrs, ld, fly, odd, cd, rdy);
      step(nrs, ld, fly, odd, cd, rdy);
    end
    check("reached_sync", stage, STAGE_SYNC);
    new_round_start = 0; load_done = 0; has_message_flying = 0;
    has_odd_clusters = 0; calc_done = 0; result_ready = 0;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_rst_stage", stage, STAGE_IDLE);
    check("async_rst_iter", iteration_counter, 0);
    check("async_rst_cycles", cycle_counter, 0);
    check("async_rst_flags", {start_pending, calc_go, result_valid, deadlock, result_status}, 0);
    check("async_rst_perf", perf_spread_cycles | perf_sync_cycles | perf_grow_cycles, 0);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b0;

    run_round(0, 2, 2, 3);
    check("post_reset_status", hold_status, RESULT_STATUS_OK);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
